// File: rtl/range_tracker.sv
// Windowed per-lane min/max/span monitor over a valid/ready sample stream.
// Result registered one cycle after the closing/flushing beat; in_ready drops only when a window's last beat would find the result slot busy.
module range_tracker #(
  parameter int W      = 4,
  parameter int N      = 2,
  parameter int WIN    = 8,
  parameter int SIGNED = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*W-1:0]           in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*W-1:0]           out_min,
  output logic [N*W-1:0]           out_max,
  output logic [N*W-1:0]           out_span,
  output logic [$clog2(WIN+1)-1:0] out_cnt
);
  localparam int CW = $clog2(WIN+1);
  localparam logic [CW-1:0] LAST = CW'(WIN-1);
  localparam logic [CW-1:0] FULL = CW'(WIN);

  typedef enum logic {ACCUM, STALL} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]  cnt, cnt_nxt, res_cnt;
  logic           flush_pend, flush_pend_nxt, pend_eff;
  logic           slot_free, acc, close, fire, load, out_valid_nxt;
  logic [N*W-1:0] acc_min, acc_max, new_min, new_max;
  logic [N*W-1:0] res_min, res_max, res_span;

  function automatic logic lt(input logic [W-1:0] a, input logic [W-1:0] b);
    if (SIGNED != 0) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  // First beat of a window seeds the accumulators instead of comparing.
  for (genvar c = 0; c < N; c++) begin : g_lane
    logic [W-1:0] s;
    assign s = in_data[c*W +: W];
    assign new_min[c*W +: W]  = (cnt == '0 || lt(s, acc_min[c*W +: W])) ? s : acc_min[c*W +: W];
    assign new_max[c*W +: W]  = (cnt == '0 || lt(acc_max[c*W +: W], s)) ? s : acc_max[c*W +: W];
    assign res_span[c*W +: W] = res_max[c*W +: W] - res_min[c*W +: W];
  end

  assign res_min   = acc ? new_min : acc_min;
  assign res_max   = acc ? new_max : acc_max;
  assign slot_free = !out_valid || out_ready;
  // STALL means the next beat closes the window while a result is still held.
  assign in_ready  = !(state == STALL && !out_ready);

  always_comb begin
    state_nxt      = ACCUM;
    cnt_nxt        = cnt;
    flush_pend_nxt = flush_pend;
    out_valid_nxt  = out_valid && !out_ready;
    pend_eff       = flush_pend || flush;
    acc            = in_valid && in_ready;
    close          = acc && (cnt == LAST);
    fire           = pend_eff && slot_free && (cnt != '0 || acc);
    load           = close || fire;
    res_cnt        = close ? FULL : cnt + CW'(acc);
    if (load) begin
      cnt_nxt        = '0;
      flush_pend_nxt = 1'b0;
      out_valid_nxt  = 1'b1;
    end else begin
      cnt_nxt        = cnt + CW'(acc);
      flush_pend_nxt = pend_eff && (cnt_nxt != '0);
    end
    if (cnt_nxt == LAST && out_valid_nxt) state_nxt = STALL;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ACCUM;
      cnt        <= '0;
      flush_pend <= 1'b0;
      out_valid  <= 1'b0;
      acc_min    <= '0;
      acc_max    <= '0;
      out_min    <= '0;
      out_max    <= '0;
      out_span   <= '0;
      out_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      flush_pend <= flush_pend_nxt;
      out_valid  <= out_valid_nxt;
      if (acc) begin
        acc_min <= new_min;
        acc_max <= new_max;
      end
      if (load) begin
        out_min  <= res_min;
        out_max  <= res_max;
        out_span <= res_span;
        out_cnt  <= res_cnt;
      end
    end
  end
endmodule

// File: tb/tb_range_tracker.sv
// Scoreboard bench for range_tracker: unsigned and signed instances share one stimulus stream.
module tb_range_tracker;
  localparam int W = 4, N = 2, WIN = 4;

  typedef struct packed {
    logic [7:0] mn;
    logic [7:0] mx;
    logic [7:0] sp;
    logic [2:0] cnt;
  } res_t;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, flush, out_ready;
  logic [7:0] in_data;
  logic       ir0, ov0, ir1, ov1;
  logic [7:0] mn0, mx0, sp0, mn1, mx1, sp1;
  logic [2:0] cnt0, cnt1;

  range_tracker #(.W(W), .N(N), .WIN(WIN), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .flush(flush), .out_valid(ov0), .out_ready(out_ready), .out_min(mn0),
    .out_max(mx0), .out_span(sp0), .out_cnt(cnt0));

  range_tracker #(.W(W), .N(N), .WIN(WIN), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .flush(flush), .out_valid(ov1), .out_ready(out_ready), .out_min(mn1),
    .out_max(mx1), .out_span(sp1), .out_cnt(cnt1));

  int npass = 0, ntot = 0;
  res_t q0[$], q1[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: min/max over the beats of a window using plain integer arithmetic.
  function automatic res_t model_res(input logic [7:0] b[$], input bit sgn);
    res_t r;
    r = '0;
    for (int c = 0; c < N; c++) begin
      int mn, mx, v;
      mn = 1000;
      mx = -1000;
      foreach (b[i]) begin
        v = int'(b[i][c*4 +: 4]);
        if (sgn && v > 7) v -= 16;
        if (v < mn) mn = v;
        if (v > mx) mx = v;
      end
      r.mn[c*4 +: 4] = 4'(mn);
      r.mx[c*4 +: 4] = 4'(mx);
      r.sp[c*4 +: 4] = 4'(mx - mn);
    end
    r.cnt = 3'(b.size());
    return r;
  endfunction

  // Reference model: beats of the open window, held-result flag, pending flush.
  logic [7:0] win[$];
  bit m_busy = 0, m_pend = 0, rst_seen = 0;

  always @(negedge clk) begin
    bit exp_rdy, accd, close, fire, pend_eff;
    exp_rdy = !(win.size() == WIN-1 && m_busy && !out_ready);
    if (rst_seen) begin
      check("in_ready_u", ir0, exp_rdy);
      check("in_ready_s", ir1, exp_rdy);
      check("out_valid_u", ov0, m_busy);
      check("out_valid_s", ov1, m_busy);
    end
    if (!rst) begin
      rst_seen = 1;
      win.delete();
      q0.delete();
      q1.delete();
      m_busy = 0;
      m_pend = 0;
    end else if (rst_seen) begin
      accd = in_valid && exp_rdy;
      if (accd) win.push_back(in_data);
      pend_eff = m_pend || flush;
      close = accd && win.size() == WIN;
      fire = pend_eff && (!m_busy || out_ready) && win.size() > 0;
      if (close || fire) begin
        q0.push_back(model_res(win, 1'b0));
        q1.push_back(model_res(win, 1'b1));
        win.delete();
        m_pend = 0;
        m_busy = 1;
      end else begin
        if (out_ready) m_busy = 0;
        m_pend = pend_eff && win.size() > 0;
      end
    end
  end

  // Monitor: pop and compare on each output handshake.
  always @(negedge clk) begin
    res_t r;
    if (rst === 1'b1 && ov0 === 1'b1 && out_ready && q0.size() != 0) begin
      r = q0.pop_front();
      check("min_u", mn0, r.mn);
      check("max_u", mx0, r.mx);
      check("span_u", sp0, r.sp);
      check("cnt_u", cnt0, r.cnt);
    end
    if (rst === 1'b1 && ov1 === 1'b1 && out_ready && q1.size() != 0) begin
      r = q1.pop_front();
      check("min_s", mn1, r.mn);
      check("max_s", mx1, r.mx);
      check("span_s", sp1, r.sp);
      check("cnt_s", cnt1, r.cnt);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic f, input logic r);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, r);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b1; in_data = 8'hFF; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    check("rst_out_valid", ov0, 0);
    check("rst_min", mn0, 0);
    check("rst_max", mx0, 0);
    check("rst_span", sp0, 0);
    check("rst_cnt", cnt0, 0);
    check("rst_in_ready", ir0, 1);
    check("rst_min_s", mn1, 0);
    check("rst_cnt_s", cnt1, 0);
    @(posedge clk);
    #1;

    // Unsigned window: lane0 3,9,1,7; lane1 F,0,F,0.
    cyc(1, 8'hF3, 0, 1); cyc(1, 8'h09, 0, 1); cyc(1, 8'hF1, 0, 1); cyc(1, 8'h07, 0, 1);
    idle(2, 1);
    // Signed/unsigned contrast: lane0 7,8,0,F.
    cyc(1, 8'h27, 0, 1); cyc(1, 8'h58, 0, 1); cyc(1, 8'hA0, 0, 1); cyc(1, 8'h3F, 0, 1);
    idle(2, 1);

    // Backpressure: stream continuously with the result held.
    for (int i = 0; i < 10; i++) cyc(1, 8'(i * 37 + 5), 0, 0);
    cyc(1, 8'h6C, 0, 1);
    idle(3, 0);
    idle(3, 1);

    // Flush of a partial window, flush while empty, flush during busy slot.
    cyc(1, 8'h15, 0, 1); cyc(1, 8'h42, 0, 1); cyc(0, 8'h00, 1, 1);
    idle(2, 1);
    cyc(0, 8'h00, 1, 1);
    idle(2, 1);
    for (int i = 0; i < 4; i++) cyc(1, 8'(i * 91 + 3), 0, 0);
    cyc(1, 8'hC4, 0, 0); cyc(1, 8'h2B, 0, 0); cyc(0, 8'h00, 1, 0);
    idle(3, 0);
    idle(4, 1);

    // Reset with a partial window and a held result.
    for (int i = 0; i < 6; i++) cyc(1, 8'(i * 53 + 11), 0, 0);
    rst = 1'b0;
    cyc(1, 8'hEE, 0, 0);
    rst = 1'b1;
    cyc(1, 8'h1A, 0, 1); cyc(1, 8'h2B, 0, 1); cyc(1, 8'h3C, 0, 1); cyc(1, 8'h4D, 0, 1);
    idle(2, 1);

    // Randomized traffic with sparse flushes and rare resets.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      cyc($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 15) == 0,
          $urandom_range(0, 2) != 0);
    end
    rst = 1'b1;
    idle(6, 1);
    check("drain_q_u", q0.size(), 0);
    check("drain_q_s", q1.size(), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
